// File: rtl/matmul_sequencer_if.sv
// Bundle of control, memory-port and multiplier-port signals for
// the matrix-multiply sequencer; the sequencer is the master.
interface matmul_sequencer_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    logic          go;
    logic          busy;
    logic          finished;
    logic          error;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rdata;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_start;
    logic [DW-1:0] mul_result;
    logic          mul_done;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;

    modport master (
        input  go, a_rdata, b_rdata, mul_result, mul_done,
        output busy, finished, error,
        output a_addr, b_addr, mul_a, mul_b, mul_start,
        output c_we, c_addr, c_wdata
    );

    modport slave (
        output go, a_rdata, b_rdata, mul_result, mul_done,
        input  busy, finished, error,
        input  a_addr, b_addr, mul_a, mul_b, mul_start,
        input  c_we, c_addr, c_wdata
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequences C = A x B through a single-element multiplier,
// accumulating N products per C element; all outputs registered.
module matmul_sequencer #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    matmul_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, WAIT_DONE, CAPTURE, WRITE, FINISH
    } state_t;

    localparam int         TW   = $clog2(TIMEOUT + 1);
    localparam logic [4:0] LAST = 5'(N - 1);

    state_t        state, state_n;
    logic [4:0]    i, j, k, i_n, j_n, k_n;
    logic [DW-1:0] acc, acc_n, sum;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          err_q, err_n, fin_q, fin_n, busy_q, busy_n;
    logic          start_q, start_n, we_q, we_n;
    logic [AW-1:0] a_addr_q, a_addr_n, b_addr_q, b_addr_n;
    logic [AW-1:0] c_addr_q, c_addr_n;
    logic [DW-1:0] mul_a_q, mul_a_n, mul_b_q, mul_b_n;
    logic [DW-1:0] c_wdata_q, c_wdata_n;

    function automatic logic [AW-1:0] idx(input logic [4:0] r,
                                          input logic [4:0] c);
        return AW'(32'(r) * 32'(N) + 32'(c));
    endfunction

    assign sum = acc + bus.mul_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        i_n       = i;
        j_n       = j;
        k_n       = k;
        acc_n     = acc;
        tcnt_n    = tcnt;
        err_n     = err_q;
        fin_n     = 1'b0;
        start_n   = 1'b0;
        we_n      = 1'b0;
        a_addr_n  = a_addr_q;
        b_addr_n  = b_addr_q;
        mul_a_n   = mul_a_q;
        mul_b_n   = mul_b_q;
        c_addr_n  = c_addr_q;
        c_wdata_n = c_wdata_q;
        unique case (state)
            IDLE: begin
                if (bus.go) begin
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                    acc_n   = '0;
                    err_n   = 1'b0;
                    state_n = FETCH;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                mul_a_n = bus.a_rdata;
                mul_b_n = bus.b_rdata;
                start_n = 1'b1;
                tcnt_n  = '0;
                state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                tcnt_n = tcnt + TW'(1);
                // tcnt==0 is the issue cycle, where a done is stale
                if (tcnt != '0 && bus.mul_done) begin
                    state_n = CAPTURE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    fin_n   = 1'b1;
                    state_n = FINISH;
                end
            end
            CAPTURE: begin
                acc_n = sum;
                if (k == LAST) begin
                    we_n      = 1'b1;
                    c_addr_n  = idx(i, j);
                    c_wdata_n = sum;
                    state_n   = WRITE;
                end else begin
                    k_n     = k + 5'd1;
                    state_n = FETCH;
                end
            end
            WRITE: begin
                acc_n = '0;
                k_n   = '0;
                if (j == LAST) begin
                    j_n = '0;
                    i_n = i + 5'd1;
                end else begin
                    j_n = j + 5'd1;
                end
                if (i == LAST && j == LAST) begin
                    fin_n   = 1'b1;
                    state_n = FINISH;
                end else begin
                    state_n = FETCH;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // addresses are presented during FETCH, so load them on entry
        if (state_n == FETCH) begin
            a_addr_n = idx(i_n, k_n);
            b_addr_n = idx(k_n, j_n);
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc       <= '0;
            tcnt      <= '0;
            err_q     <= 1'b0;
            fin_q     <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            we_q      <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            c_addr_q  <= '0;
            c_wdata_q <= '0;
        end else begin
            i         <= i_n;
            j         <= j_n;
            k         <= k_n;
            acc       <= acc_n;
            tcnt      <= tcnt_n;
            err_q     <= err_n;
            fin_q     <= fin_n;
            busy_q    <= busy_n;
            start_q   <= start_n;
            we_q      <= we_n;
            a_addr_q  <= a_addr_n;
            b_addr_q  <= b_addr_n;
            mul_a_q   <= mul_a_n;
            mul_b_q   <= mul_b_n;
            c_addr_q  <= c_addr_n;
            c_wdata_q <= c_wdata_n;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.finished  = fin_q;
    assign bus.error     = err_q;
    assign bus.a_addr    = a_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_start = start_q;
    assign bus.c_we      = we_q;
    assign bus.c_addr    = c_addr_q;
    assign bus.c_wdata   = c_wdata_q;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer at N=2 with behavioural
// A/B memories and a two-stage multiplier model.
module tb_matmul_sequencer;
    localparam int N       = 2;
    localparam int DW      = 32;
    localparam int AW      = 8;
    localparam int TIMEOUT = 15;
    localparam int NOMCYC  = N * N * (5 * N + 1);

    typedef struct packed {
        logic [3:0][DW-1:0] a;
        logic [3:0][DW-1:0] b;
        logic [3:0][DW-1:0] c;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    matmul_sequencer #(
        .N(N), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] amem [4];
    logic [DW-1:0] bmem [4];
    logic          mul_en;
    logic          mdone;
    logic [DW-1:0] prod, mres;

    // done one cycle after start, product one cycle after done
    always @(posedge clk) begin
        bus.a_rdata <= amem[bus.a_addr[1:0]];
        bus.b_rdata <= bmem[bus.b_addr[1:0]];
        mdone       <= mul_en && bus.mul_start;
        if (bus.mul_start) prod <= bus.mul_a * bus.mul_b;
        if (mdone) mres <= prod;
    end
    assign bus.mul_done   = mdone;
    assign bus.mul_result = mres;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fin_cyc = 0;
    int fin_cnt = 0;
    logic busy_d = 1'b0, we_d = 1'b0, st_d = 1'b0, fin_d = 1'b0;
    logic [AW-1:0] waddr [$];
    logic [DW-1:0] wdata [$];

    always begin
        @(posedge clk);
        #1;
        if (bus.busy && !busy_d) cyc = 0;
        else cyc++;
        busy_d = bus.busy;
        if (bus.c_we) begin
            waddr.push_back(bus.c_addr);
            wdata.push_back(bus.c_wdata);
        end
        if (bus.finished) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
        if (bus.c_we || bus.mul_start || bus.finished) begin
            n_cmp++;
            if ((bus.c_we && we_d) || (bus.mul_start && st_d) ||
                (bus.finished && fin_d)) begin
                n_bad++;
                $display("FAIL pulse_width: strobe high two cycles at t=%0t",
                         $time);
            end
        end
        we_d  = bus.c_we;
        st_d  = bus.mul_start;
        fin_d = bus.finished;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {bus.busy, bus.finished, bus.error, bus.a_addr, bus.b_addr,
                bus.mul_a, bus.mul_b, bus.mul_start, bus.c_we, bus.c_addr,
                bus.c_wdata};
    endfunction

    function automatic vec_t mk(
        input logic [DW-1:0] a0, a1, a2, a3,
        input logic [DW-1:0] b0, b1, b2, b3,
        input logic [DW-1:0] c0, c1, c2, c3);
        vec_t v;
        v.a = {a3, a2, a1, a0};
        v.b = {b3, b2, b1, b0};
        v.c = {c3, c2, c1, c0};
        return v;
    endfunction

    vec_t vt [4];

    task automatic load(input int v);
        for (int e = 0; e < 4; e++) begin
            amem[e] = vt[v].a[e];
            bmem[e] = vt[v].b[e];
        end
        waddr.delete();
        wdata.delete();
    endtask

    task automatic pulse_go();
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic wait_fin(input int f0, input int budget, input string nm);
        int c = 0;
        while (fin_cnt == f0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_finished_seen"}, 128'(fin_cnt != f0), 128'(1));
    endtask

    task automatic verify(input int v, input string nm);
        chk({nm, "_write_count"}, 128'(waddr.size()), 128'(4));
        for (int e = 0; e < 4; e++) begin
            if (e < waddr.size()) begin
                chk($sformatf("%s_addr%0d", nm, e), 128'(waddr[e]), 128'(e));
                chk($sformatf("%s_data%0d", nm, e), 128'(wdata[e]),
                    128'(vt[v].c[e]));
            end
        end
        chk({nm, "_error"}, 128'(bus.error), 128'(0));
    endtask

    task automatic run_check(input int v, input string nm);
        int f0;
        load(v);
        f0 = fin_cnt;
        pulse_go();
        wait_fin(f0, 300, nm);
        verify(v, nm);
        chk({nm, "_latency"}, 128'(fin_cyc), 128'(NOMCYC));
    endtask

    initial begin
        int f0;
        int c;
        vt[0] = mk(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
        vt[1] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFF, 1, 1, 1, 1, 32'hFFFF_FFFE,
                   32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        vt[2] = mk(32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000,
                   32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000,
                   0, 0, 0, 0);
        vt[3] = mk(2, 0, 0, 3, 4, 5, 6, 7, 8, 10, 18, 21);
        mul_en = 1'b1;
        bus.go = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs(), 128'(0));

        for (int v = 0; v < 4; v++) run_check(v, $sformatf("vec%0d", v));

        // go held high, with an extra re-assertion mid-run
        load(0);
        f0 = fin_cnt;
        @(negedge clk);
        bus.go = 1'b1;
        repeat (20) @(negedge clk);
        bus.go = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
        wait_fin(f0, 300, "gohold");
        bus.go = 1'b0;
        repeat (10) @(negedge clk);
        verify(0, "gohold");
        chk("gohold_fin_count", 128'(fin_cnt - f0), 128'(1));
        chk("gohold_latency", 128'(fin_cyc), 128'(NOMCYC));

        // reset during the second element's WAIT_DONE
        load(0);
        f0 = fin_cnt;
        pulse_go();
        c = 0;
        while (!(waddr.size() == 1 && bus.mul_start) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("rst_reached_elem2", 128'(c < 300), 128'(1));
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", outs(), 128'(0));
        @(negedge clk);
        chk("rst_next_cycle_outputs", outs(), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_more_writes", 128'(waddr.size()), 128'(1));
        chk("rst_no_finished", 128'(fin_cnt - f0), 128'(0));
        run_check(0, "after_rst");

        // multiplier never completes
        mul_en = 1'b0;
        load(0);
        f0 = fin_cnt;
        pulse_go();
        wait_fin(f0, 200, "timeout");
        chk("timeout_error", 128'(bus.error), 128'(1));
        chk("timeout_no_write", 128'(waddr.size()), 128'(0));
        chk("timeout_latency", 128'(fin_cyc), 128'(2 + TIMEOUT));
        repeat (5) @(negedge clk);
        chk("timeout_error_sticky", 128'(bus.error), 128'(1));
        chk("timeout_fin_count", 128'(fin_cnt - f0), 128'(1));
        mul_en = 1'b1;
        load(0);
        f0 = fin_cnt;
        pulse_go();
        chk("go_clears_error", 128'({bus.busy, bus.error}), 128'(2'b10));
        wait_fin(f0, 300, "post_timeout");
        verify(0, "post_timeout");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Initiator that computes C = A x B for square N x N matrices of 32-bit unsigned elements by driving the single-element multiplier (mul_a/mul_b/mul_start in, mul_result/mul_done back).
- Reads A and B from synchronous-read memories, accumulates N partial products per C element, and writes each C element to a result memory.
- Sits between the matrix storage and the multiplier element; software or a top-level FSM pulses go and waits for finished.

Parameters:
N, 4, matrix dimension (2..16)
DW, 32, data width of elements, products and accumulator
AW, 8, address width of A/B/C memories (must hold N*N-1)
TIMEOUT, 15, max cycles in WAIT_DONE before abort

Ports:
clk  in  1  system clock
rst  in  1  reset
go  in  1  start request, sampled in IDLE only
busy  out  1  high in any state other than IDLE
finished  out  1  one-cycle pulse on completion or abort
error  out  1  sticky timeout flag, cleared when next go is accepted
a_addr  out  AW  A read address, row-major: i*N+k
a_rdata  in  DW  A read data, valid the cycle after a_addr
b_addr  out  AW  B read address, row-major: k*N+j
b_rdata  in  DW  B read data, valid the cycle after b_addr
mul_a  out  DW  operand to multiplier
mul_b  out  DW  operand to multiplier
mul_start  out  1  one-cycle issue strobe to multiplier
mul_result  in  DW  multiplier product, valid the cycle after mul_done
mul_done  in  1  multiplier completion strobe
c_we  out  1  C write enable, one cycle per element
c_addr  out  AW  C write address: i*N+j
c_wdata  out  DW  C element value

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: all outputs 0.
- Reset also clears i, j, k, acc and the timeout counter, and forces IDLE.
- All outputs are registered.
- States: IDLE, FETCH, LOAD, WAIT_DONE, CAPTURE, WRITE, FINISH.
- IDLE: on go=1, clear i/j/k/acc/error and go to FETCH; go=0 stays in IDLE.
- FETCH (1 cycle): drive a_addr=i*N+k and b_addr=k*N+j, then go to LOAD.
- LOAD (1 cycle): register mul_a<=a_rdata and mul_b<=b_rdata, set mul_start<=1, then go to WAIT_DONE.
- WAIT_DONE:
  - mul_start is high only in the first WAIT_DONE cycle.
  - The first WAIT_DONE cycle ignores mul_done.
  - From the second cycle on, mul_done=1 goes to CAPTURE.
  - The timeout counter increments each cycle; reaching TIMEOUT sets error=1 and goes to FINISH with no C write.
- CAPTURE (1 cycle): acc <= acc + mul_result, modulo 2^DW, no saturation.
  - If k==N-1, go to WRITE.
  - Otherwise k++ and go to FETCH.
- WRITE (1 cycle): c_we=1, c_addr=i*N+j, c_wdata=acc; then clear acc and k.
  - Advance j, wrapping to 0 and incrementing i at j==N-1.
  - If i==N-1 and j==N-1, go to FINISH; otherwise go to FETCH.
- FINISH (1 cycle): finished=1, busy stays 1, then go to IDLE.
- Nominal timing:
  - 5 cycles per term (FETCH, LOAD, WAIT_DONE x2, CAPTURE) with a 1-cycle-done multiplier.
  - FINISH is entered N*N*(5N+1) cycles after the first FETCH cycle.
- Boundary conditions:
  - go while busy is ignored, with no restart.
  - mul_done outside WAIT_DONE is ignored.
  - A truncated multiplier product is accumulated as delivered.
  - Async reset mid-operation aborts immediately: no c_we, no finished pulse.
  - error remains 1 after an abort and is not cleared by FINISH.
- c_we, mul_start and finished are never high for more than one consecutive cycle.

Test Plan:
- Basic product, N=2: A=[[1,2],[3,4]], B=[[5,6],[7,8]] with a behavioural multiplier (done one cycle after start, result one cycle later) -> c writes (0,19),(1,22),(2,43),(3,50) in order; finished pulses 44 cycles after the first FETCH; error=0.
- Accumulator wrap, N=2: A all 0xFFFFFFFF, B all 1 -> every C element 0xFFFFFFFE.
- Truncation, N=2: A all 0x00010000, B all 0x00010000 -> every C element 0.
- go held high throughout the run, plus a second go pulse mid-run -> exactly one sequence of 4 c_we pulses and a single finished pulse.
- Reset mid-run: assert rst during the 2nd element's WAIT_DONE -> all outputs 0 next cycle, no further c_we; a new go then produces correct results from (0,0).
- Timeout: multiplier model never asserts mul_done -> after TIMEOUT cycles in WAIT_DONE, error=1 and finished pulses once, no c_we; the next go clears error.
